// File: rtl/cache_exerciser_pkg.sv
// Shared definitions for the cache exerciser: FSM states, pattern modes,
// LFSR polynomial and error-counter helpers.
package cache_exerciser_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR        = 3'd1,
        WR_WAIT   = 3'd2,
        RD_SETTLE = 3'd3,
        RD_WAIT   = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_ADDR  = 2'd1;
    localparam logic [1:0] MODE_NADDR = 2'd2;
    localparam logic [1:0] MODE_LFSR  = 2'd3;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    localparam int ERROR_COUNT_BITWIDTH = 16;

    // One step of the Galois LFSR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
    endfunction

    // Error counter increment that sticks at all ones.
    function automatic logic [ERROR_COUNT_BITWIDTH-1:0] error_count_increment(
        input logic [ERROR_COUNT_BITWIDTH-1:0] c
    );
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

endpackage

// File: rtl/cache_exerciser_pattern_generator.sv
// Test-data source for the exerciser. Produces the word for the current
// address in the selected mode; the LFSR is reloaded at the start of each
// pass and stepped once per word so both passes see the same sequence.
module pattern_generator
    import cache_exerciser_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH = 32,
    parameter int DATA_BITWIDTH = 32,
    parameter logic [DATA_BITWIDTH-1:0] CONST_PATTERN = 32'h1234_5678,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  mode,
    input  logic                        load,
    input  logic                        step,
    input  logic [ADDRESS_BITWIDTH-1:0] address,
    output logic [DATA_BITWIDTH-1:0]    word
);

    logic [31:0]              lfsr_r;
    logic [DATA_BITWIDTH-1:0] addr_word_s;

    // LFSR state: reload takes priority over stepping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= LFSR_SEED;
        end else if (load) begin
            lfsr_r <= LFSR_SEED;
        end else if (step) begin
            lfsr_r <= lfsr_step(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // Select the data word for the current mode and address.
    always_comb begin
        word        = '0;
        addr_word_s = DATA_BITWIDTH'(address);
        case (mode)
            MODE_CONST: word = CONST_PATTERN;
            MODE_ADDR:  word = addr_word_s;
            MODE_NADDR: word = ~addr_word_s;
            MODE_LFSR: begin
                for (int i = 0; i < DATA_BITWIDTH; i++) begin
                    word[i] = lfsr_r[i % 32];
                end
            end
            default:    word = '0;
        endcase
    end

endmodule

// File: rtl/cache_exerciser.sv
// Built-in self-test sequencer for the cache CPU port: writes a pattern over
// a word range, reads it back, and reports mismatches/timeouts.
module cache_exerciser
    import cache_exerciser_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH = 32,
    parameter int DATA_BITWIDTH = 32,
    parameter logic [ADDRESS_BITWIDTH-1:0] START_ADDRESS = '0,
    parameter int unsigned WORD_COUNT = 1024,
    parameter logic [DATA_BITWIDTH-1:0] CONST_PATTERN = 32'h1234_5678,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_0001,
    parameter int unsigned TIMEOUT_CYCLES = 255
)(
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic                            start,
    input  logic [1:0]                      mode,
    output logic [ADDRESS_BITWIDTH-1:0]     cache_address,
    output logic [DATA_BITWIDTH-1:0]        cache_data_in,
    output logic [DATA_BITWIDTH/8-1:0]      cache_write_enable,
    input  logic [DATA_BITWIDTH-1:0]        cache_data_out,
    input  logic                            cache_data_out_valid,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [ERROR_COUNT_BITWIDTH-1:0] error_count,
    output logic                            timeout_seen,
    output logic [ADDRESS_BITWIDTH-1:0]     first_error_address
);

    localparam int BYTE_LANES = DATA_BITWIDTH / 8;
    localparam logic [ADDRESS_BITWIDTH-1:0] ADDRESS_STEP = ADDRESS_BITWIDTH'(BYTE_LANES);
    localparam logic [31:0] LAST_INDEX    = 32'(WORD_COUNT - 32'd1);
    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

    state_t                            state_r;
    state_t                            state_next_s;
    logic [1:0]                        mode_r;
    logic [ADDRESS_BITWIDTH-1:0]       address_r;
    logic [31:0]                       word_index_r;
    logic [31:0]                       wait_cnt_r;
    logic                              busy_r;
    logic                              done_r;
    logic                              pass_r;
    logic                              timeout_r;
    logic [ERROR_COUNT_BITWIDTH-1:0]   error_count_r;
    logic [ADDRESS_BITWIDTH-1:0]       first_error_r;
    logic [DATA_BITWIDTH-1:0]          pattern_word_s;

    logic start_run_s;
    logic advance_s;
    logic last_word_s;
    logic timed_out_s;
    logic err_hit_s;
    logic timeout_hit_s;
    logic wait_clear_s;
    logic pattern_load_s;
    logic pattern_step_s;

    pattern_generator #(
        .ADDRESS_BITWIDTH (ADDRESS_BITWIDTH),
        .DATA_BITWIDTH    (DATA_BITWIDTH),
        .CONST_PATTERN    (CONST_PATTERN),
        .LFSR_SEED        (LFSR_SEED)
    ) u_pattern (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .mode    (mode_r),
        .load    (pattern_load_s),
        .step    (pattern_step_s),
        .address (address_r),
        .word    (pattern_word_s)
    );

    // FSM state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic plus per-cycle control strobes.
    always_comb begin
        state_next_s  = state_r;
        start_run_s   = 1'b0;
        advance_s     = 1'b0;
        err_hit_s     = 1'b0;
        timeout_hit_s = 1'b0;
        wait_clear_s  = 1'b0;
        last_word_s   = (word_index_r == LAST_INDEX);
        timed_out_s   = ((wait_cnt_r + 32'd1) >= TIMEOUT_LIMIT);
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    start_run_s  = 1'b1;
                    state_next_s = WR;
                end else begin
                    state_next_s = state_r;
                end
            end
            WR: begin
                wait_clear_s = 1'b1;
                state_next_s = WR_WAIT;
            end
            WR_WAIT: begin
                if (cache_data_out_valid) begin
                    advance_s = 1'b1;
                end else if (timed_out_s) begin
                    advance_s     = 1'b1;
                    err_hit_s     = 1'b1;
                    timeout_hit_s = 1'b1;
                end else begin
                    advance_s = 1'b0;
                end
                if (advance_s) begin
                    state_next_s = last_word_s ? RD_SETTLE : WR;
                end else begin
                    state_next_s = WR_WAIT;
                end
            end
            RD_SETTLE: begin
                wait_clear_s = 1'b1;
                state_next_s = RD_WAIT;
            end
            RD_WAIT: begin
                if (cache_data_out_valid) begin
                    advance_s = 1'b1;
                    err_hit_s = (cache_data_out != pattern_word_s);
                end else if (timed_out_s) begin
                    advance_s     = 1'b1;
                    err_hit_s     = 1'b1;
                    timeout_hit_s = 1'b1;
                end else begin
                    advance_s = 1'b0;
                end
                if (advance_s) begin
                    state_next_s = last_word_s ? DONE : RD_SETTLE;
                end else begin
                    state_next_s = RD_WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        // Reload at run start and when rewinding for the read pass.
        pattern_load_s = start_run_s | ((state_r == WR_WAIT) & advance_s & last_word_s);
        pattern_step_s = advance_s & ~last_word_s;
    end

    // Wait-cycle counter; restarts from zero on entry to each wait state.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wait_cnt_r <= 32'd0;
        end else if (wait_clear_s) begin
            wait_cnt_r <= 32'd0;
        end else if (((state_r == WR_WAIT) || (state_r == RD_WAIT)) && (wait_cnt_r != 32'hFFFF_FFFF)) begin
            wait_cnt_r <= wait_cnt_r + 32'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Run control: mode latch, address/word walk, busy/done/pass flags.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_r       <= 2'd0;
            address_r    <= '0;
            word_index_r <= 32'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
        end else if (start_run_s) begin
            mode_r       <= mode;
            address_r    <= START_ADDRESS;
            word_index_r <= 32'd0;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
        end else if (advance_s) begin
            if (last_word_s) begin
                word_index_r <= 32'd0;
                address_r    <= START_ADDRESS;
                if (state_r == RD_WAIT) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    pass_r <= (error_count_r == 16'd0) & ~err_hit_s;
                end else begin
                    busy_r <= busy_r;
                    done_r <= done_r;
                    pass_r <= pass_r;
                end
            end else begin
                word_index_r <= word_index_r + 32'd1;
                address_r    <= address_r + ADDRESS_STEP;
            end
        end else begin
            mode_r       <= mode_r;
            address_r    <= address_r;
            word_index_r <= word_index_r;
        end
    end

    // Error bookkeeping: saturating count, sticky timeout, first failing address.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            error_count_r <= 16'd0;
            timeout_r     <= 1'b0;
            first_error_r <= '0;
        end else if (start_run_s) begin
            error_count_r <= 16'd0;
            timeout_r     <= 1'b0;
            first_error_r <= '0;
        end else if (err_hit_s) begin
            error_count_r <= error_count_increment(error_count_r);
            timeout_r     <= timeout_r | timeout_hit_s;
            if (error_count_r == 16'd0) begin
                first_error_r <= address_r;
            end else begin
                first_error_r <= first_error_r;
            end
        end else begin
            error_count_r <= error_count_r;
            timeout_r     <= timeout_r;
            first_error_r <= first_error_r;
        end
    end

    // The write strobe and data are decoded from the registered state only.
    assign cache_address       = address_r;
    assign cache_data_in       = (state_r == WR) ? pattern_word_s : '0;
    assign cache_write_enable  = (state_r == WR) ? '1 : '0;
    assign busy                = busy_r;
    assign done                = done_r;
    assign pass                = pass_r;
    assign error_count         = error_count_r;
    assign timeout_seen        = timeout_r;
    assign first_error_address = first_error_r;

endmodule

// File: tb/tb_cache_exerciser.sv
// Self-checking bench for cache_exerciser: behavioural cache with one-cycle
// valid, fault injection (read corruption, missing valid), directed table
// plus randomized runs checked against an expectation model.
module tb_cache_exerciser;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WC = 16;
    localparam int TO = 15;
    localparam logic [31:0] START = 32'h0000_0100;
    localparam logic [31:0] CONSTP = 32'h1234_5678;
    localparam logic [31:0] SEED = 32'hACE1_0001;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] cache_address;
    logic [31:0] cache_data_in;
    logic [3:0]  cache_write_enable;
    logic [31:0] cache_data_out;
    logic        cache_data_out_valid;
    logic        busy, done, pass, timeout_seen;
    logic [15:0] error_count;
    logic [31:0] first_error_address;

    cache_exerciser #(
        .ADDRESS_BITWIDTH (AW),
        .DATA_BITWIDTH    (DW),
        .START_ADDRESS    (START),
        .WORD_COUNT       (WC),
        .CONST_PATTERN    (CONSTP),
        .LFSR_SEED        (SEED),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .sys_clk              (sys_clk),
        .sys_rst              (sys_rst),
        .start                (start),
        .mode                 (mode),
        .cache_address        (cache_address),
        .cache_data_in        (cache_data_in),
        .cache_write_enable   (cache_write_enable),
        .cache_data_out       (cache_data_out),
        .cache_data_out_valid (cache_data_out_valid),
        .busy                 (busy),
        .done                 (done),
        .pass                 (pass),
        .error_count          (error_count),
        .timeout_seen         (timeout_seen),
        .first_error_address  (first_error_address)
    );

    always #5 sys_clk = ~sys_clk;

    // Cache model: valid is low for the first cycle after an address change.
    logic [31:0] mem [0:255];
    logic [31:0] prev_addr = 32'd0;
    logic        corrupt_en = 1'b0;
    logic        block_en = 1'b0;
    logic [31:0] corrupt_addr = 32'd0;
    logic [31:0] block_addr = 32'd0;

    initial for (int i = 0; i < 256; i++) mem[i] = 32'd0;

    always @(posedge sys_clk) begin
        prev_addr <= cache_address;
        if (cache_write_enable == 4'hF) mem[cache_address[9:2]] <= cache_data_in;
    end

    assign cache_data_out_valid = (cache_address == prev_addr) && !(block_en && (cache_address == block_addr));
    assign cache_data_out = mem[cache_address[9:2]] ^ ((corrupt_en && (cache_address == corrupt_addr)) ? 32'h1 : 32'h0);

    // Write monitor, sampled on the falling edge.
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int          wr_cycle [$];
    int          cyc = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (cache_write_enable == 4'hF) begin
            wr_addr.push_back(cache_address);
            wr_data.push_back(cache_data_in);
            wr_cycle.push_back(cyc);
        end
    end

    int total = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] lfsr_after(input int n);
        logic [31:0] s;
        s = SEED;
        for (int k = 0; k < n; k++) begin
            if (s[0]) s = (s >> 1) ^ 32'h8020_0003;
            else      s = s >> 1;
        end
        return s;
    endfunction

    function automatic logic [31:0] model_word(input logic [1:0] m, input int idx);
        logic [31:0] a;
        a = START + 32'(4 * idx);
        case (m)
            2'd0:    return CONSTP;
            2'd1:    return a;
            2'd2:    return ~a;
            default: return lfsr_after(idx);
        endcase
    endfunction

    typedef struct {
        logic [1:0]  mode;
        bit          corrupt_en;
        logic [31:0] corrupt_addr;
        bit          block_en;
        logic [31:0] block_addr;
        bit          mid_start;
        int          exp_errors;
        bit          exp_pass;
        bit          exp_timeout;
        logic [31:0] exp_first;
    } vec_t;

    // Errors in run order: write pass (timeouts only), then read pass.
    task automatic model_status(input vec_t v, output int errs, output logic [31:0] first);
        logic [31:0] a;
        bit e;
        errs = 0;
        first = 32'd0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < WC; i++) begin
                a = START + 32'(4 * i);
                e = (v.block_en && a == v.block_addr) ||
                    (p == 1 && v.corrupt_en && a == v.corrupt_addr);
                if (e) begin
                    if (errs == 0) first = a;
                    errs++;
                end
            end
        end
    endtask

    task automatic do_run(input vec_t v, input string tag);
        bit finished;
        int j;
        finished = 1'b0;
        corrupt_en = v.corrupt_en;
        corrupt_addr = v.corrupt_addr;
        block_en = v.block_en;
        block_addr = v.block_addr;
        wr_addr.delete();
        wr_data.delete();
        wr_cycle.delete();
        @(negedge sys_clk);
        mode = v.mode;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        for (int k = 0; k < 3000 && !finished; k++) begin
            @(negedge sys_clk);
            if (v.mid_start && k == 40) begin
                start = 1'b1;
                mode = ~v.mode;
            end else begin
                start = 1'b0;
            end
            if (done) finished = 1'b1;
        end
        start = 1'b0;
        check($sformatf("%s done", tag), {63'd0, finished}, 64'd1);
        check($sformatf("%s busy", tag), {63'd0, busy}, 64'd0);
        check($sformatf("%s pass", tag), {63'd0, pass}, {63'd0, v.exp_pass});
        check($sformatf("%s error_count", tag), {48'd0, error_count}, 64'(v.exp_errors));
        check($sformatf("%s timeout_seen", tag), {63'd0, timeout_seen}, {63'd0, v.exp_timeout});
        check($sformatf("%s first_error", tag), {32'd0, first_error_address}, {32'd0, v.exp_first});
        check($sformatf("%s write_count", tag), 64'(wr_addr.size()), 64'(WC));
        if (wr_addr.size() == WC) begin
            for (int i = 0; i < WC; i++) begin
                check($sformatf("%s wr_addr[%0d]", tag, i), {32'd0, wr_addr[i]}, {32'd0, START + 32'(4 * i)});
                check($sformatf("%s wr_data[%0d]", tag, i), {32'd0, wr_data[i]}, {32'd0, model_word(v.mode, i)});
            end
            if (v.block_en) begin
                j = int'((v.block_addr - START) >> 2);
                if (j < WC - 1)
                    check($sformatf("%s timeout_gap", tag), 64'(wr_cycle[j + 1] - wr_cycle[j]), 64'(TO + 1));
            end
        end
    endtask

    vec_t vecs [7];
    vec_t rv;
    int   errs;
    logic [31:0] first;
    bit   filled;

    initial begin
        // mode, corrupt, c_addr, block, b_addr, mid_start, errors, pass, timeout, first
        vecs[0] = '{2'd0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 0, 1'b1, 1'b0, 32'h0};
        vecs[1] = '{2'd1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 0, 1'b1, 1'b0, 32'h0};
        vecs[2] = '{2'd1, 1'b1, 32'h108, 1'b0, 32'h0,   1'b0, 1, 1'b0, 1'b0, 32'h108};
        vecs[3] = '{2'd2, 1'b0, 32'h0,   1'b1, 32'h108, 1'b0, 2, 1'b0, 1'b1, 32'h108};
        vecs[4] = '{2'd3, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 0, 1'b1, 1'b0, 32'h0};
        vecs[5] = '{2'd0, 1'b1, 32'h13C, 1'b0, 32'h0,   1'b0, 1, 1'b0, 1'b0, 32'h13C};
        vecs[6] = '{2'd3, 1'b1, 32'h100, 1'b1, 32'h10C, 1'b0, 3, 1'b0, 1'b1, 32'h10C};

        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("reset outputs", {busy, done, pass, timeout_seen, error_count, first_error_address,
              cache_address, cache_data_in, cache_write_enable} == '0 ? 64'd1 : 64'd0, 64'd1);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        for (int i = 0; i < 7; i++) do_run(vecs[i], $sformatf("vec%0d", i));

        for (int r = 0; r < 6; r++) begin
            rv.mode = 2'($urandom_range(0, 3));
            rv.corrupt_en = 1'($urandom_range(0, 1));
            rv.corrupt_addr = START + 32'(4 * $urandom_range(0, WC - 1));
            rv.block_en = ($urandom_range(0, 3) == 0);
            rv.block_addr = START + 32'(4 * $urandom_range(0, WC - 1));
            rv.mid_start = 1'($urandom_range(0, 1));
            model_status(rv, errs, first);
            rv.exp_errors = errs;
            rv.exp_first = first;
            rv.exp_pass = (errs == 0);
            rv.exp_timeout = rv.block_en;
            do_run(rv, $sformatf("rand%0d", r));
        end

        // Reset in the middle of the read pass, then a clean rerun.
        corrupt_en = 1'b0;
        block_en = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        wr_cycle.delete();
        @(negedge sys_clk);
        mode = 2'd1;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        filled = 1'b0;
        for (int k = 0; k < 500 && !filled; k++) begin
            @(negedge sys_clk);
            if (wr_addr.size() == WC) filled = 1'b1;
        end
        check("midreset write pass finished", {63'd0, filled}, 64'd1);
        repeat (3) @(posedge sys_clk);
        #2;
        check("midreset busy before", {63'd0, busy}, 64'd1);
        sys_rst = 1'b1;
        #1;
        check("midreset outputs", {busy, done, pass, timeout_seen, error_count, first_error_address,
              cache_address, cache_data_in, cache_write_enable} == '0 ? 64'd1 : 64'd0, 64'd1);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        do_run(vecs[1], "after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
